// File: rtl/dmem_arbiter_if.sv
// Core/debug/RAM bundle shared between the data-memory arbiter and its neighbours.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  // Core load/store path
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  // Debug/DMA burst port
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [3:0]    dbg_len;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic          dbg_beat;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;

  // Single-port RAM, asynchronous read
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    output dbg_ack, dbg_beat, dbg_rvalid, dbg_rdata, dbg_done,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Requester / memory side
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    input  dbg_ack, dbg_beat, dbg_rvalid, dbg_rdata, dbg_done,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: core has priority, burst port gets a forced slot after MAX_WAIT blocked cycles.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CW = 4;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state, state_nxt;
  logic          b_we, b_we_nxt;
  logic [AW-1:0] b_addr, b_addr_nxt;
  logic [CW-1:0] b_cnt, b_cnt_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          ack_q, ack_nxt;
  logic          rvalid_q, rvalid_nxt;
  logic [DW-1:0] rdata_q, rdata_nxt;
  logic          done_q, done_nxt;
  logic          force_beat;
  logic          beat;

  // State and registered-output update; reset drops any burst in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      b_we     <= 1'b0;
      b_addr   <= '0;
      b_cnt    <= '0;
      wait_cnt <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      b_we     <= b_we_nxt;
      b_addr   <= b_addr_nxt;
      b_cnt    <= b_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      ack_q    <= ack_nxt;
      rvalid_q <= rvalid_nxt;
      rdata_q  <= rdata_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state logic plus the combinational RAM mux, beat and stall
  always_comb begin
    state_nxt    = state;
    b_we_nxt     = b_we;
    b_addr_nxt   = b_addr;
    b_cnt_nxt    = b_cnt;
    wait_cnt_nxt = wait_cnt;
    ack_nxt      = 1'b0;
    rvalid_nxt   = 1'b0;
    rdata_nxt    = rdata_q;
    done_nxt     = 1'b0;

    force_beat = (state == BURST) && (wait_cnt == CW'(MAX_WAIT));
    beat       = (state == BURST) && (!bus.core_req || force_beat);

    bus.dbg_beat   = beat;
    bus.core_stall = beat & bus.core_req;
    bus.core_rdata = bus.ram_rdata;

    bus.ram_we    = bus.core_req & bus.core_we;
    bus.ram_addr  = bus.core_addr;
    bus.ram_wdata = bus.core_wdata;
    if (beat) begin
      bus.ram_we    = b_we;
      bus.ram_addr  = b_addr;
      bus.ram_wdata = bus.dbg_wdata;
    end
    // No RAM writes while reset is held, whatever the registers contain
    if (!reset) begin
      bus.ram_we = 1'b0;
    end

    case (state)
      IDLE: begin
        if (bus.dbg_req) begin
          state_nxt    = BURST;
          b_we_nxt     = bus.dbg_we;
          b_addr_nxt   = bus.dbg_addr;
          b_cnt_nxt    = bus.dbg_len;
          wait_cnt_nxt = '0;
          ack_nxt      = 1'b1;
        end
      end
      BURST: begin
        if (beat) begin
          b_addr_nxt   = b_addr + AW'(1);
          wait_cnt_nxt = '0;
          rvalid_nxt   = !b_we;
          if (!b_we) begin
            rdata_nxt = bus.ram_rdata;
          end
          if (b_cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            b_cnt_nxt = b_cnt - CW'(1);
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dbg_ack    = ack_q;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_done   = done_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural async-read RAM.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(32)) bus ();

  dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM model: asynchronous read, synchronous write
  logic [31:0] mem [256];
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;

  // {ack, beat, stall, ram_we, rvalid, done}
  logic [5:0] flags;
  assign flags = {bus.dbg_ack, bus.dbg_beat, bus.core_stall, bus.ram_we, bus.dbg_rvalid, bus.dbg_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.core_req = 1'b1; bus.core_we = 1'b1;
    bus.core_addr = 8'h10; bus.core_wdata = 32'h1234_5678;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_len = '0; bus.dbg_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      tests_run++;
      if ({flags, bus.dbg_rdata} !== 38'h0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc %0d: flags=%b rdata=%h want 000000/0", i, flags, bus.dbg_rdata);
      end
    end
    tick(); reset = 1'b1; #1;
    tests_run++;
    if ({bus.ram_we, bus.ram_addr} !== 9'h110) begin
      tests_failed++;
      $display("FAIL reset_store: we=%b addr=%h want 1/10", bus.ram_we, bus.ram_addr);
    end
    tick(); bus.core_we = 1'b0; #1;
    tests_run++;
    if (bus.core_rdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL reset_load: got %h want 12345678", bus.core_rdata);
    end
    bus.core_req = 1'b0;
  endtask

  task automatic test_idle_write();
    logic [5:0] exp_f [5];
    logic [7:0] exp_a [5];
    exp_f = '{6'b110100, 6'b010100, 6'b010100, 6'b010100, 6'b000001};
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00};
    tick();
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'hFE; bus.dbg_len = 4'd3;
    #1;
    tests_run++;
    if (flags !== 6'b000000) begin
      tests_failed++;
      $display("FAIL idle_write_pre: flags=%b want 000000", flags);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.dbg_req = 1'b0;
      bus.dbg_wdata = 32'hA000_0000 + 32'(i);
      #1;
      tests_run++;
      if (flags !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL idle_write_flags cyc %0d: got %b want %b", i, flags, exp_f[i]);
      end
      if (i < 4) begin
        tests_run++;
        if (bus.ram_addr !== exp_a[i]) begin
          tests_failed++;
          $display("FAIL idle_write_addr cyc %0d: got %h want %h", i, bus.ram_addr, exp_a[i]);
        end
      end
    end
    tests_run++;
    if (mem[8'hFE] !== 32'hA000_0000 || mem[8'hFF] !== 32'hA000_0001 ||
        mem[8'h00] !== 32'hA000_0002 || mem[8'h01] !== 32'hA000_0003) begin
      tests_failed++;
      $display("FAIL idle_write_mem: FE=%h FF=%h 00=%h 01=%h want A0000000..A0000003",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] exp_f [11];
    exp_f = '{6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b011000, 6'b000010,
              6'b000000, 6'b000000, 6'b000000, 6'b011000, 6'b000011};
    tick();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h40; bus.core_wdata = 32'hCAFE_0001;
    tick();
    bus.core_addr = 8'h41; bus.core_wdata = 32'hCAFE_0002;
    tick();
    bus.core_we = 1'b0; bus.core_addr = 8'h05;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h40; bus.dbg_len = 4'd1;
    for (int i = 0; i < 11; i++) begin
      tick();
      bus.dbg_req = 1'b0;
      #1;
      tests_run++;
      if (flags !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL starve_flags cyc %0d: got %b want %b", i, flags, exp_f[i]);
      end
      if (i == 4 || i == 9) begin
        tests_run++;
        if (bus.ram_addr !== ((i == 4) ? 8'h40 : 8'h41)) begin
          tests_failed++;
          $display("FAIL starve_addr cyc %0d: got %h", i, bus.ram_addr);
        end
      end
      if (i == 5 || i == 10) begin
        tests_run++;
        if (bus.dbg_rdata !== ((i == 5) ? 32'hCAFE_0001 : 32'hCAFE_0002)) begin
          tests_failed++;
          $display("FAIL starve_rdata cyc %0d: got %h", i, bus.dbg_rdata);
        end
      end
    end
    bus.core_req = 1'b0;
  endtask

  task automatic test_interleave();
    logic [5:0] exp_f [9];
    exp_f = '{6'b100000, 6'b010100, 6'b000000, 6'b010100, 6'b000000,
              6'b010100, 6'b000000, 6'b010100, 6'b000001};
    tick();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 8'h05;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h80; bus.dbg_len = 4'd3;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.dbg_req = 1'b0;
      bus.core_req = (i % 2 == 0);
      bus.dbg_wdata = 32'hB000_0000 + 32'(i);
      #1;
      tests_run++;
      if (flags !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL interleave_flags cyc %0d: got %b want %b", i, flags, exp_f[i]);
      end
    end
    bus.core_req = 1'b0;
    tests_run++;
    if (mem[8'h80] !== 32'hB000_0001 || mem[8'h81] !== 32'hB000_0003 ||
        mem[8'h82] !== 32'hB000_0005 || mem[8'h83] !== 32'hB000_0007) begin
      tests_failed++;
      $display("FAIL interleave_mem: 80=%h 81=%h 82=%h 83=%h want B0000001/3/5/7",
               mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_f [2];
    exp_f = '{6'b110100, 6'b010100};
    tick();
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h20; bus.dbg_len = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.dbg_req = 1'b0;
      bus.dbg_wdata = 32'hD000_0000 + 32'(i);
      #1;
      tests_run++;
      if (flags !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL reset_mid_flags cyc %0d: got %b want %b", i, flags, exp_f[i]);
      end
    end
    tick(); reset = 1'b0; #1;
    tests_run++;
    if (flags !== 6'b010000) begin
      tests_failed++;
      $display("FAIL reset_mid_we: flags=%b want 010000", flags);
    end
    tick(); reset = 1'b1; #1;
    tests_run++;
    if (flags !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: flags=%b want 000000", flags);
    end
    tick(); #1;
    tests_run++;
    if (flags !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_mid_nodone: flags=%b want 000000", flags);
    end
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h30; bus.dbg_len = 4'd0;
    tick(); bus.dbg_req = 1'b0; #1;
    tests_run++;
    if ({flags, bus.ram_addr} !== {6'b110100, 8'h30}) begin
      tests_failed++;
      $display("FAIL reset_mid_newack: flags=%b addr=%h want 110100/30", flags, bus.ram_addr);
    end
    tick(); #1;
    tests_run++;
    if (flags !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_mid_newdone: flags=%b want 000001", flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_f [7];
    exp_f = '{6'b110100, 6'b010100, 6'b000001, 6'b110100, 6'b010100, 6'b000001, 6'b000000};
    tick();
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h50; bus.dbg_len = 4'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 3) bus.dbg_req = 1'b0;
      #1;
      tests_run++;
      if (flags !== exp_f[i]) begin
        tests_failed++;
        $display("FAIL back_to_back_flags cyc %0d: got %b want %b", i, flags, exp_f[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_starvation();
    test_interleave();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
    $fatal(1);
  end
endmodule
